// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: serialises writeback rd/base-update writes through one register-file port, with forwarding
module regfile_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pri_valid,
    input  logic [3:0]  pri_addr,
    input  logic [31:0] pri_data,
    input  logic        sec_valid,
    input  logic [3:0]  sec_addr,
    input  logic [31:0] sec_data,
    output logic        stall,
    output logic        rf_w_en,
    output logic [3:0]  rf_w_addr,
    output logic [31:0] rf_w_data,
    input  logic [3:0]  qry_addr,
    output logic        qry_hit,
    output logic [31:0] qry_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [3:0]    q_addr_q [DEPTH];
    logic [31:0]   q_data_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail_p1;
    logic [CW-1:0] count_q, count_d;
    logic          en_q, en_d;
    logic [3:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          pv, sv, take_q, enq_pri, enq_sec;
    assign stall     = count_q == CW'(DEPTH);
    assign rf_w_en   = en_q;
    assign rf_w_addr = addr_q;
    assign rf_w_data = data_q;
    // Order this cycle's work: queue head first, then primary, then secondary; the rest goes to the queue
    always_comb begin
        pv      = pri_valid & ~stall;
        sv      = sec_valid & ~stall & ~(pri_valid & (pri_addr == sec_addr));
        take_q  = count_q != '0;
        enq_pri = pv & take_q;
        enq_sec = sv & (take_q | pv);
        en_d    = take_q | pv | sv;
        addr_d  = take_q ? q_addr_q[head_q] : pv ? pri_addr : sv ? sec_addr : addr_q;
        data_d  = take_q ? q_data_q[head_q] : pv ? pri_data : sv ? sec_data : data_q;
        head_d  = head_q + PW'(take_q);
        tail_p1 = tail_q + PW'(1);
        tail_d  = tail_q + PW'(enq_pri) + PW'(enq_sec);
        count_d = count_q + CW'(enq_pri) + CW'(enq_sec) - CW'(take_q);
    end
    // Output register and queue bookkeeping; reset drops everything pending
    always_ff @(posedge clk) begin
        if (rst_n) begin
            en_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    // Queue storage needs no reset: only entries counted by count_q are ever read
    always_ff @(posedge clk) begin
        if (enq_pri | enq_sec) begin
            q_addr_q[tail_q] <= enq_pri ? pri_addr : sec_addr;
            q_data_q[tail_q] <= enq_pri ? pri_data : sec_data;
        end
        if (enq_pri & enq_sec) begin
            q_addr_q[tail_p1] <= sec_addr;
            q_data_q[tail_p1] <= sec_data;
        end
    end
    // Forwarding: scan oldest to youngest so the youngest match overrides earlier ones
    always_comb begin
        qry_hit  = en_q & (addr_q == qry_addr);
        qry_data = qry_hit ? data_q : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && q_addr_q[head_q + PW'(i)] == qry_addr) begin
                qry_hit  = 1'b1;
                qry_data = q_data_q[head_q + PW'(i)];
            end
        end
        if (pv && pri_addr == qry_addr) begin
            qry_hit  = 1'b1;
            qry_data = pri_data;
        end
        if (sv && sec_addr == qry_addr) begin
            qry_hit  = 1'b1;
            qry_data = sec_data;
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Sequences all register-file writes from the writeback stage through the single register-file write port. Each cycle the writeback stage presents up to two requests from one instruction:
- **Primary:** the rd result, from an ALU op or LDR load data.
- **Secondary:** the base-register update for a pre/post-indexed LDR/STR with W set.

The arbiter serialises these requests in program order through a small pending queue. It back-pressures the writeback stage when the queue is full, and it forwards the youngest pending value of any register to the decode/operand-read logic.

## Interface
Parameters:
- DEPTH, 4, pending-queue capacity in entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-high reset (codebase port name; asserted = 1)
- pri_valid  in  1  primary write request (rd)
- pri_addr  in  4  primary destination register
- pri_data  in  32  primary write data
- sec_valid  in  1  secondary write request (base update)
- sec_addr  in  4  secondary destination register
- sec_data  in  32  secondary write data
- stall  out  1  queue full; requests this cycle are not accepted
- rf_w_en  out  1  register-file write enable
- rf_w_addr  out  4  register-file write address
- rf_w_data  out  32  register-file write data
- qry_addr  in  4  register number queried by operand read
- qry_hit  out  1  a pending write to qry_addr exists
- qry_data  out  32  youngest pending value for qry_addr

## Operation
- **State.**
  - Output register holding rf_w_en/addr/data.
  - Circular FIFO Q of DEPTH {addr, data} entries, with head/tail pointers and a count of width clog2(DEPTH)+1.
- **Acceptance.** Requests are accepted only when stall = 0.
  - With stall = 1, pri_valid and sec_valid are ignored; the upstream holds them until stall drops.
- **Same-address pair.** If pri_valid and sec_valid are both set with pri_addr == sec_addr, the secondary is dropped and only the primary is written.
- **Ordering.** Each cycle, form the ordered sequence: Q entries oldest→youngest, then accepted primary, then accepted secondary.
  - The first element loads the output register with rf_w_en = 1.
  - The remaining elements stay in or enter Q in that order.
  - If the sequence is empty, rf_w_en = 0 next cycle; rf_w_addr/rf_w_data hold their previous values.
- **Stall.** stall = (count == DEPTH), decoded from registered count; no combinational path from the request inputs.
  - Net count change per cycle is at most +1 when accepting and −1 when idle, so Q never overflows.
- **Forwarding lookup** (combinational). Search for qry_addr in this order, youngest first:
  1. accepted secondary
  2. accepted primary
  3. Q tail→head
  4. output register, if rf_w_en = 1
  - First match drives qry_hit = 1 and qry_data; no match gives qry_hit = 0 and qry_data = 0.
  - Unaccepted requests (stall = 1) are not searched.
- **r15.** Writes to r15 are treated as any other register; PC redirection is not this block's concern.
- **Reset.** Reset in any cycle, including mid-drain, discards Q and the output register; pending writes are lost.

## Timing
- **Reset values:** stall = 0, rf_w_en = 0, rf_w_addr = 0, rf_w_data = 0, count = 0, pointers = 0. qry_hit = 0 whenever no requests are presented.
- **Latency with empty Q:** a primary accepted in cycle N appears on rf_w_* in cycle N+1; a secondary accepted with it appears in N+2.
- **Latency with k entries in Q:** an accepted request appears after all k entries, in cycle N+k+1.
- **Throughput:** exactly one register-file write per cycle while work is pending.
- **Full boundary:** with count = DEPTH−1 and both requests accepted, count becomes DEPTH and stall = 1 the following cycle. Stall deasserts the cycle after count drops below DEPTH.
- **Wrap-around:** head/tail wrap modulo DEPTH; order is preserved across the wrap.
- **Reset timing:** rst_n = 1 at edge N forces reset values in cycle N+1 regardless of inputs.

## Test plan
- **Reset:** hold rst_n = 1 for 2 cycles with random inputs → stall = 0, rf_w_en = 0, rf_w_addr = 0, rf_w_data = 0 throughout; qry_hit = 0 when no requests are presented.
- **Single write:** pri r3 = 0x11 in cycle N → cycle N+1 rf_w_en = 1, addr 3, data 0x11; cycle N+2 rf_w_en = 0.
- **LDR with writeback:** pri r1 = 0xAAAA and sec r2 = 0x1004 in cycle N → r1 written in N+1, r2 in N+2. Same pair with both addresses = r5 → only r5 = 0xAAAA is written, once.
- **Fill and back-pressure (DEPTH = 4):** present pri+sec pairs every cycle, holding each pair while stall = 1, using 8 pairs with unique addr/data.
  - stall rises once count reaches 4.
  - All 16 writes appear on consecutive cycles in program order with none lost or duplicated; pointers wrap at least once.
- **Forwarding:**
  - r7 = 0x77 pending in Q with qry_addr = 7 → qry_hit = 1, qry_data = 0x77.
  - Same cycle with sec r7 = 0x99 accepted → qry_data = 0x99.
  - qry_addr = 8 → qry_hit = 0.
- **Reset mid-operation:** with Q holding 3 entries, assert rst_n for 1 cycle → next cycle rf_w_en = 0, stall = 0, and none of the discarded writes ever appear.
